// File: rtl/xvc_pkg.sv
// xvc_pkg
// Shared definitions for the XVC JTAG shift path: the shifter FSM state
// encoding, byte width, default TCK half-period and the largest TMS/TDI
// vector (in bytes) a single shift command may carry. The command parser
// uses XVC_MAX_VECTOR_BYTES to size its buffers.
package xvc_pkg;

    localparam int XVC_BYTE_W                  = 8;
    localparam int XVC_DEFAULT_TCK_HALF_PERIOD = 4;
    localparam int XVC_MAX_VECTOR_BYTES        = 1024;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        EMIT,
        FINISH
    } xvc_state_t;

endpackage

// File: rtl/xvc_tck_gen.sv
// xvc_tck_gen
// Half-period timer for the JTAG clock. While enabled it counts clock cycles
// and strobes phase_end on the last cycle of each TCK half-period, then
// restarts from zero. While disabled it holds its count, so a stalled shifter
// resumes exactly where it paused.
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   enable    in   count this cycle (shifter is in a LOW or HIGH phase)
//   phase_end out  last cycle of the current half-period (only while enabled)
module xvc_tck_gen #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic phase_end
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] count_reg;

    assign phase_end = enable && (count_reg == TERMINAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= phase_end ? '0 : count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/xvc_jtag_shifter.sv
// xvc_jtag_shifter
// Executes one XVC "shift:" command. Accepts num_bits, then pulls paired
// TMS/TDI bytes (LSB first, ascending byte order), drives TCK/TMS/TDI, and
// returns captured TDO bytes (LSB = first captured bit). Exactly
// ceil(num_bits/8) bytes are consumed and emitted. Upstream or downstream
// backpressure parks the engine with TCK low and TMS/TDI held.
//
// Ports:
//   clock, reset                 system clock, asynchronous active-low reset
//   cmd_valid/ready/num_bits     command handshake and TCK cycle count
//   vec_valid/ready/tms/tdi      TMS/TDI byte pair input
//   tdo_valid/ready/data         captured TDO byte output
//   busy                         command in progress
//   done                         one-cycle pulse on command completion
//   jtag_tck/tms/tdi             JTAG pin drivers
//   jtag_tdo                     JTAG TDO input (asynchronous)
module xvc_jtag_shifter
    import xvc_pkg::*;
#(
    parameter int TCK_HALF_PERIOD = XVC_DEFAULT_TCK_HALF_PERIOD,
    parameter int LEN_WIDTH       = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_num_bits,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [XVC_BYTE_W-1:0] vec_tms,
    input  logic [XVC_BYTE_W-1:0] vec_tdi,
    output logic                  tdo_valid,
    input  logic                  tdo_ready,
    output logic [XVC_BYTE_W-1:0] tdo_data,
    output logic                  busy,
    output logic                  done,
    output logic                  jtag_tck,
    output logic                  jtag_tms,
    output logic                  jtag_tdi,
    input  logic                  jtag_tdo
);

    xvc_state_t state_reg, state_next;

    logic [LEN_WIDTH-1:0]  remaining_reg;
    logic [2:0]            bit_idx_reg;
    logic [XVC_BYTE_W-1:0] tms_sr_reg;
    logic [XVC_BYTE_W-1:0] tdi_sr_reg;
    logic [XVC_BYTE_W-1:0] tdo_sr_reg;
    logic                  tck_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  tdo_meta_reg;
    logic                  tdo_sync_reg;
    logic                  phase_end;
    logic                  last_bit_of_byte;

    xvc_tck_gen #(
        .HALF_PERIOD (TCK_HALF_PERIOD)
    ) u_tck_gen (
        .clock     (clock),
        .reset     (reset),
        .enable    ((state_reg == LOW) || (state_reg == HIGH)),
        .phase_end (phase_end)
    );

    // The byte ends either on the eighth bit or on the final bit of the command.
    assign last_bit_of_byte = (bit_idx_reg == 3'd7) || (remaining_reg == LEN_WIDTH'(1));

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        vec_ready  = 1'b0;
        tdo_valid  = 1'b0;
        tdo_data   = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = (cmd_num_bits == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                vec_ready = 1'b1;
                if (vec_valid) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_next = last_bit_of_byte ? EMIT : LOW;
                end
            end
            EMIT: begin
                tdo_valid = 1'b1;
                tdo_data  = tdo_sr_reg;
                if (tdo_ready) begin
                    // remaining was already decremented on the last HIGH phase
                    state_next = (remaining_reg == '0) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The two TDO flops are a plain synchronizer: jtag_tdo is asynchronous.
    // TDO is sampled at the end of the HIGH phase, so the two-cycle latency is
    // well inside a half-period of at least three cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tdo_meta_reg <= 1'b0;
            tdo_sync_reg <= 1'b0;
        end else begin
            tdo_meta_reg <= jtag_tdo;
            tdo_sync_reg <= tdo_meta_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            bit_idx_reg   <= '0;
            // Bit 0 of the TMS register drives the pin; idle TMS is high.
            tms_sr_reg    <= XVC_BYTE_W'(1);
            tdi_sr_reg    <= '0;
            tdo_sr_reg    <= '0;
            tck_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == FINISH);
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        remaining_reg <= cmd_num_bits;
                        bit_idx_reg   <= '0;
                        tdo_sr_reg    <= '0;
                        busy_reg      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (vec_valid) begin
                        tms_sr_reg <= vec_tms;
                        tdi_sr_reg <= vec_tdi;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        tck_reg <= 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        tck_reg                 <= 1'b0;
                        tdo_sr_reg[bit_idx_reg] <= tdo_sync_reg;
                        bit_idx_reg             <= bit_idx_reg + 3'd1;
                        if (remaining_reg != '0) begin
                            remaining_reg <= remaining_reg - LEN_WIDTH'(1);
                        end
                        // Only advance to the next bit when another LOW phase
                        // follows; otherwise the pins keep the last bit during
                        // EMIT/FETCH stalls and after the command ends.
                        if (!last_bit_of_byte) begin
                            tms_sr_reg <= {1'b0, tms_sr_reg[XVC_BYTE_W-1:1]};
                            tdi_sr_reg <= {1'b0, tdi_sr_reg[XVC_BYTE_W-1:1]};
                        end
                    end
                end
                EMIT: begin
                    if (tdo_ready) begin
                        tdo_sr_reg <= '0;
                    end
                end
                FINISH: begin
                    busy_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign jtag_tck = tck_reg;
    assign jtag_tms = tms_sr_reg[0];
    assign jtag_tdi = tdi_sr_reg[0];

endmodule

// File: tb/tb_xvc_jtag_shifter.sv
module tb_xvc_jtag_shifter;

    localparam int H        = 4;
    localparam int EDGE_MAX = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_num_bits = '0;
    logic        vec_valid = 1'b0;
    logic        vec_ready;
    logic [7:0]  vec_tms = '0;
    logic [7:0]  vec_tdi = '0;
    logic        tdo_valid;
    logic        tdo_ready = 1'b1;
    logic [7:0]  tdo_data;
    logic        busy;
    logic        done;
    logic        jtag_tck;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;

    logic loopback  = 1'b1;
    logic tdo_const = 1'b0;
    assign jtag_tdo = loopback ? jtag_tdi : tdo_const;

    int checks = 0;
    int errors = 0;

    logic [7:0] tms_q[$];
    logic [7:0] tdi_q[$];
    logic [7:0] got_q[$];

    // results of the last run_cmd
    int r_vec, r_done, r_lat, r_vready_cnt, r_vready_over, r_stall_obs, r_stall_tck;
    int r_busy_gap, r_ready_busy, r_edges, r_e0;
    bit r_timeout, r_aborted;

    xvc_jtag_shifter #(
        .TCK_HALF_PERIOD (H),
        .LEN_WIDTH       (32)
    ) dut (
        .clock        (clk),
        .reset        (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_num_bits (cmd_num_bits),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_tms      (vec_tms),
        .vec_tdi      (vec_tdi),
        .tdo_valid    (tdo_valid),
        .tdo_ready    (tdo_ready),
        .tdo_data     (tdo_data),
        .busy         (busy),
        .done         (done),
        .jtag_tck     (jtag_tck),
        .jtag_tms     (jtag_tms),
        .jtag_tdi     (jtag_tdi),
        .jtag_tdo     (jtag_tdo)
    );

    always #5 clk = ~clk;

    // ---------------- pin monitor: records every TCK rising edge ----------------
    int   edge_n = 0, low_run = 0, high_run = 0, stable_run = 0, viol_hi = 0;
    logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;
    logic edge_tms [EDGE_MAX];
    logic edge_tdi [EDGE_MAX];
    int   edge_low [EDGE_MAX];
    int   edge_high[EDGE_MAX];
    int   edge_setup[EDGE_MAX];
    logic pin_changed;
    assign pin_changed = (jtag_tms !== prev_tms) || (jtag_tdi !== prev_tdi);

    always @(negedge clk) begin
        prev_tck   <= jtag_tck;
        prev_tms   <= jtag_tms;
        prev_tdi   <= jtag_tdi;
        stable_run <= pin_changed ? 1 : stable_run + 1;
        if (pin_changed && jtag_tck) viol_hi <= viol_hi + 1;
        if (jtag_tck && !prev_tck) begin
            if (edge_n < EDGE_MAX) begin
                edge_tms[edge_n]   <= jtag_tms;
                edge_tdi[edge_n]   <= jtag_tdi;
                edge_low[edge_n]   <= low_run;
                edge_setup[edge_n] <= pin_changed ? 0 : stable_run;
            end
            edge_n   <= edge_n + 1;
            high_run <= 1;
        end else if (jtag_tck) begin
            high_run <= high_run + 1;
        end else if (prev_tck) begin
            if (edge_n > 0 && edge_n <= EDGE_MAX) edge_high[edge_n-1] <= high_run;
            low_run <= 1;
        end else begin
            low_run <= low_run + 1;
        end
    end

    // ---------------- reference model ----------------
    // Expected TDO byte k of an nb-bit shift: bit j holds what the target
    // presented on TDO for command bit 8k+j; bits past nb read 0.
    function automatic logic [7:0] model_tdo_byte(input int k, input int nb);
        logic [7:0] src, b;
        src = tdi_q[k];
        b   = '0;
        for (int j = 0; j < 8; j++)
            if (8*k + j < nb) b[j] = loopback ? src[j] : tdo_const;
        return b;
    endfunction

    function automatic logic model_bit(input logic [7:0] q[$], input int i);
        logic [7:0] by;
        by = q[i/8];
        return by[i%8];
    endfunction

    task automatic fill_vectors(input int nb);
        tms_q.delete();
        tdi_q.delete();
        for (int k = 0; k < (nb + 7) / 8; k++) begin
            tms_q.push_back(8'($urandom));
            tdi_q.push_back(8'($urandom));
        end
    endtask

    // ---------------- stimulus driver ----------------
    task automatic run_cmd(input int nb, input int stall_len, input int abort_edge);
        int nbytes, fed, stall_left;
        bit hs_v, hs_t, triggered;
        nbytes = (nb + 7) / 8;
        fed = 0; stall_left = 0; triggered = 0;
        got_q.delete();
        r_vec = 0; r_done = 0; r_lat = -1; r_vready_cnt = 0; r_vready_over = 0;
        r_stall_obs = 0; r_stall_tck = 0; r_busy_gap = 0; r_ready_busy = 0;
        r_aborted = 0; r_timeout = 1;
        @(posedge clk); #1;
        r_e0 = edge_n;
        cmd_valid = 1'b1;
        cmd_num_bits = 32'(nb);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin r_timeout = 0; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_num_bits = $urandom;
        if (r_timeout) return;
        r_timeout = 1;
        tdo_ready = (stall_len == 0);
        vec_valid = (fed < nbytes);
        vec_tms = (fed < nbytes) ? tms_q[fed] : 8'($urandom);
        vec_tdi = (fed < nbytes) ? tdi_q[fed] : 8'($urandom);
        for (int cyc = 1; cyc < 20000; cyc++) begin
            @(negedge clk);
            hs_v = vec_valid && vec_ready;
            hs_t = tdo_valid && tdo_ready;
            if (vec_ready) r_vready_cnt++;
            if (vec_ready && fed >= nbytes) r_vready_over++;
            if (hs_t) got_q.push_back(tdo_data);
            if (tdo_valid && !tdo_ready) begin
                r_stall_obs++;
                if (jtag_tck) r_stall_tck++;
            end
            if (tdo_valid && stall_len > 0 && !triggered) begin
                triggered = 1; stall_left = stall_len;
            end
            if (done) begin
                r_done++;
                if (r_lat < 0) r_lat = cyc;
            end
            if (!busy && r_lat < 0) r_busy_gap++;
            if (cmd_ready && busy) r_ready_busy++;
            if (r_lat >= 0 && cyc >= r_lat + 4) begin r_timeout = 0; break; end
            @(posedge clk); #1;
            if (hs_v) begin fed++; r_vec++; end
            vec_valid = (fed < nbytes);
            vec_tms = (fed < nbytes) ? tms_q[fed] : 8'($urandom);
            vec_tdi = (fed < nbytes) ? tdi_q[fed] : 8'($urandom);
            if (stall_left > 0) stall_left--;
            tdo_ready = (stall_len == 0) || (triggered && stall_left == 0);
            if (abort_edge >= 0 && edge_n - r_e0 > abort_edge) begin
                reset_n = 1'b0; r_aborted = 1; r_timeout = 0;
                break;
            end
        end
        #1;
        vec_valid = 1'b0;
        tdo_ready = 1'b1;
        r_edges = edge_n - r_e0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, vec_ready, tdo_valid, busy, done, jtag_tck, jtag_tms, jtag_tdi} !== 8'b1000_0010) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {cmd_ready, vec_ready, tdo_valid, busy, done, jtag_tck, jtag_tms, jtag_tdi}, 8'b1000_0010);
        end
        checks++;
        if (tdo_data !== 8'h00) begin
            errors++; $display("FAIL reset_tdo_data: got %h expected 00", tdo_data);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, jtag_tck, jtag_tms} !== 4'b1001) begin
            errors++; $display("FAIL post_reset_idle: got %b expected 1001", {cmd_ready, busy, jtag_tck, jtag_tms});
        end
        $display("test_reset: done");
    endtask

    // Runs one command and checks it against the model.
    task automatic test_shift(input string name, input int nb, input int stall_len);
        int nbytes;
        logic [7:0] exp_b, got_b;
        nbytes = (nb + 7) / 8;
        repeat (3) @(posedge clk);
        run_cmd(nb, stall_len, -1);
        checks++;
        if (r_timeout) begin errors++; $display("FAIL %s timeout: got 1 expected 0", name); return; end
        checks++;
        if (r_edges != nb) begin errors++; $display("FAIL %s tck_edges: got %0d expected %0d", name, r_edges, nb); end
        checks++;
        if (r_vec != nbytes) begin errors++; $display("FAIL %s bytes_in: got %0d expected %0d", name, r_vec, nbytes); end
        checks++;
        if (got_q.size() != nbytes) begin
            errors++; $display("FAIL %s bytes_out: got %0d expected %0d", name, got_q.size(), nbytes);
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                exp_b = model_tdo_byte(k, nb);
                got_b = got_q[k];
                checks++;
                if (got_b !== exp_b) begin
                    errors++; $display("FAIL %s tdo_byte[%0d]: got %h expected %h", name, k, got_b, exp_b);
                end
            end
        end
        checks++;
        if (r_done != 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, r_done); end
        checks++;
        if (r_vready_over != 0 || r_busy_gap != 0 || r_ready_busy != 0) begin
            errors++;
            $display("FAIL %s handshake_rules: overfetch=%0d busy_gap=%0d ready_while_busy=%0d expected all 0",
                     name, r_vready_over, r_busy_gap, r_ready_busy);
        end
        for (int i = 0; i < nb && i < r_edges; i++) begin
            checks++;
            if (edge_tms[r_e0+i] !== model_bit(tms_q, i) || edge_tdi[r_e0+i] !== model_bit(tdi_q, i)) begin
                errors++;
                $display("FAIL %s pins_at_edge[%0d]: got tms=%b tdi=%b expected tms=%b tdi=%b", name, i,
                         edge_tms[r_e0+i], edge_tdi[r_e0+i], model_bit(tms_q, i), model_bit(tdi_q, i));
            end
            checks++;
            if (edge_setup[r_e0+i] < H || edge_high[r_e0+i] != H) begin
                errors++;
                $display("FAIL %s timing[%0d]: got setup=%0d high=%0d expected setup>=%0d high=%0d",
                         name, i, edge_setup[r_e0+i], edge_high[r_e0+i], H, H);
            end
        end
        $display("%s: nb=%0d bytes_out=%0d edges=%0d done=%0d", name, nb, got_q.size(), r_edges, r_done);
    endtask

    task automatic test_byte_loopback;
        loopback = 1'b1;
        tms_q = '{8'h00};
        tdi_q = '{8'hA5};
        test_shift("byte_loopback", 8, 0);
        checks++;
        if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin
            errors++; $display("FAIL byte_loopback_A5: got %h expected a5", got_q[0]);
        end
    endtask

    task automatic test_partial_byte;
        int ones;
        loopback = 1'b0; tdo_const = 1'b1;
        tms_q = '{8'h1F};
        tdi_q = '{8'($urandom)};
        repeat (4) @(posedge clk);
        test_shift("partial_byte", 5, 0);
        ones = 0;
        for (int i = 0; i < r_edges; i++) if (edge_tms[r_e0+i] === 1'b1) ones++;
        checks++;
        if (ones != 5) begin errors++; $display("FAIL partial_tms_high: got %0d expected 5", ones); end
        checks++;
        if (got_q.size() > 0 && got_q[0] !== 8'h1F) begin
            errors++; $display("FAIL partial_tdo_1F: got %h expected 1f", got_q[0]);
        end
        loopback = 1'b1;
    endtask

    task automatic test_zero_bits;
        tms_q.delete(); tdi_q.delete();
        test_shift("zero_bits", 0, 0);
        checks++;
        if (r_vready_cnt != 0) begin errors++; $display("FAIL zero_vec_ready: got %0d cycles expected 0", r_vready_cnt); end
        checks++;
        if (r_lat != 2) begin errors++; $display("FAIL zero_done_latency: got %0d expected 2", r_lat); end
    endtask

    task automatic test_stall;
        loopback = 1'b1;
        fill_vectors(20);
        test_shift("stall", 20, 50);
        checks++;
        if (r_stall_tck != 0) begin errors++; $display("FAIL stall_tck_low: got %0d high cycles expected 0", r_stall_tck); end
        checks++;
        if (r_stall_obs < 50) begin errors++; $display("FAIL stall_length: got %0d expected >=50", r_stall_obs); end
    endtask

    task automatic test_timing;
        int v0;
        v0 = viol_hi;
        fill_vectors(8);
        test_shift("timing", 8, 0);
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (edge_low[r_e0+i] != H) begin
                errors++; $display("FAIL timing_low[%0d]: got %0d expected %0d", i, edge_low[r_e0+i], H);
            end
        end
        checks++;
        if (viol_hi != v0) begin errors++; $display("FAIL timing_pins_while_high: got %0d expected 0", viol_hi - v0); end
    endtask

    task automatic test_reset_mid;
        fill_vectors(16);
        repeat (3) @(posedge clk);
        run_cmd(16, 0, 3);
        checks++;
        if (!r_aborted) begin errors++; $display("FAIL midreset_reached_bit3: got 0 expected 1"); end
        #1;
        checks++;
        if ({cmd_ready, vec_ready, tdo_valid, busy, done, jtag_tck, jtag_tms, jtag_tdi} !== 8'b1000_0010
            || tdo_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got %b/%h expected 10000010/00",
                     {cmd_ready, vec_ready, tdo_valid, busy, done, jtag_tck, jtag_tms, jtag_tdi}, tdo_data);
        end
        checks++;
        if (r_done != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", r_done); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        fill_vectors(8);
        test_shift("after_reset", 8, 0);
        fill_vectors(3);
        test_shift("after_reset_partial", 3, 0);
    endtask

    task automatic test_random;
        int nb, stall;
        for (int n = 0; n < 8; n++) begin
            nb = int'($urandom_range(1, 40));
            loopback  = 1'($urandom_range(0, 1));
            tdo_const = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0;
            fill_vectors(nb);
            test_shift("random", nb, stall);
            checks++;
            if (r_stall_tck != 0) begin errors++; $display("FAIL random_stall_tck: got %0d expected 0", r_stall_tck); end
        end
        loopback = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_byte_loopback();
        test_partial_byte();
        test_zero_bits();
        test_stall();
        test_timing();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
